// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and load/store sequencer: latches one execute result per handshake,
// decodes funct3 into one-hot size controls for mem, and holds loads until mem stops stalling.
module ex_mem_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_write_data,
    output logic [3:0]      mem_wmask,
    output logic            mem_read_en,
    output logic [3:0]      mem_read_size,
    output logic            zero_extends,
    input  logic            stall_from_mem,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_reg_write,
    output logic            wb_is_load,
    output logic [XLEN-1:0] wb_alu_result,
    output logic            wb_misaligned
);

    typedef enum logic [1:0] {StEmpty, StIssue, StLoadWait} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] addr_q, store_data_q;
    logic [2:0]      funct3_q;
    logic            is_load_q, is_store_q, reg_write_q;
    logic [RD_W-1:0] rd_q;

    // Last completed op, so wb_* hold their value between completions.
    logic [RD_W-1:0] wb_rd_q;
    logic            wb_reg_write_q, wb_is_load_q, wb_misaligned_q;
    logic [XLEN-1:0] wb_alu_result_q;

    logic       active, completing, accept, is_store_eff, misaligned;
    logic [3:0] size_onehot;
    logic [2:0] align_mask;

    assign active       = (state_q != StEmpty);
    assign size_onehot  = 4'b0001 << funct3_q[1:0];
    assign is_store_eff = is_store_q & ~is_load_q;  // load wins if both are flagged

    always_comb begin
        align_mask = 3'b000;
        unique case (funct3_q[1:0])
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misaligned = (is_load_q | is_store_eff) & (|(addr_q[2:0] & align_mask));

    always_comb begin
        completing = 1'b0;
        unique case (state_q)
            StIssue:    completing = ~is_load_q | misaligned | ~stall_from_mem;
            StLoadWait: completing = ~stall_from_mem;
            default:    completing = 1'b0;
        endcase
    end

    assign ex_ready = ~active | completing;
    assign accept   = ex_valid & ex_ready;

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept)                  state_d = StIssue;
        else if (completing)         state_d = StEmpty;
        else if (state_q == StIssue) state_d = StLoadWait;
    end

    // Output logic
    always_comb begin
        mem_addr       = addr_q;
        mem_write_data = store_data_q;
        mem_write_en   = (state_q == StIssue) & is_store_eff & ~misaligned;
        mem_read_en    = active & is_load_q & ~misaligned;
        mem_wmask      = (active & is_store_eff) ? size_onehot : 4'b0000;
        mem_read_size  = (active & is_load_q) ? size_onehot : 4'b0000;
        zero_extends   = active & is_load_q & funct3_q[2];
        wb_valid       = completing;
        wb_rd          = completing ? rd_q : wb_rd_q;
        wb_reg_write   = completing ? (reg_write_q & ~misaligned) : wb_reg_write_q;
        wb_is_load     = completing ? is_load_q : wb_is_load_q;
        wb_alu_result  = completing ? addr_q : wb_alu_result_q;
        wb_misaligned  = completing ? misaligned : wb_misaligned_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q       <= '0;
            store_data_q <= '0;
            funct3_q     <= '0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
        end else if (accept) begin
            addr_q       <= ex_alu_result;
            store_data_q <= ex_store_data;
            funct3_q     <= ex_funct3;
            is_load_q    <= ex_is_load;
            is_store_q   <= ex_is_store;
            rd_q         <= ex_rd;
            reg_write_q  <= ex_reg_write;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_is_load_q    <= 1'b0;
            wb_alu_result_q <= '0;
            wb_misaligned_q <= 1'b0;
        end else if (completing) begin
            wb_rd_q         <= wb_rd;
            wb_reg_write_q  <= wb_reg_write;
            wb_is_load_q    <= wb_is_load;
            wb_alu_result_q <= wb_alu_result;
            wb_misaligned_q <= wb_misaligned;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic, all compared
// against an op-level reference model.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [2:0]  f3;
        logic        ld;
        logic        st;
        logic [4:0]  rd;
        logic        rw;
    } op_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ex_valid, ex_ready;
    logic [63:0] ex_alu_result, ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_is_load, ex_is_store;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [63:0] mem_addr, mem_write_data;
    logic        mem_write_en, mem_read_en, zero_extends;
    logic [3:0]  mem_wmask, mem_read_size;
    logic        stall_from_mem;
    logic        wb_valid, wb_reg_write, wb_is_load, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [63:0] wb_alu_result;

    ex_mem_stage #(.XLEN(64), .RD_W(5)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_wmask(mem_wmask), .mem_read_en(mem_read_en), .mem_read_size(mem_read_size),
        .zero_extends(zero_extends), .stall_from_mem(stall_from_mem),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_is_load(wb_is_load), .wb_alu_result(wb_alu_result), .wb_misaligned(wb_misaligned)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the op currently held, whether this is its first cycle, last writeback.
    op_t         cur;
    bit          occ, first, exp_complete;
    logic [4:0]  h_rd;
    logic        h_rw, h_ld, h_mis;
    logic [63:0] h_alu;

    function automatic op_t mk(input logic [63:0] addr, input logic [2:0] f3, input logic ld,
                               input logic st, input logic [4:0] rd, input logic rw,
                               input logic [63:0] sdata);
        op_t o;
        o.addr = addr; o.f3 = f3; o.ld = ld; o.st = st; o.rd = rd; o.rw = rw; o.sdata = sdata;
        return o;
    endfunction

    task automatic model_reset();
        occ = 0; first = 0; cur = '0;
        h_rd = '0; h_rw = 0; h_ld = 0; h_mis = 0; h_alu = '0;
    endtask

    task automatic check_cycle();
        logic        ld, st, mis, rw;
        int          nbytes;
        logic [3:0]  oh;
        ld     = cur.ld;
        st     = cur.st && !cur.ld;
        nbytes = 1 << cur.f3[1:0];
        oh     = 4'(nbytes);
        mis    = (ld || st) && ((cur.addr % 64'(nbytes)) != 0);
        exp_complete = occ && (!ld || mis || !stall_from_mem);
        rw     = cur.rw && !mis;
        check("ex_ready", 64'(ex_ready), 64'(!occ || exp_complete));
        check("wb_valid", 64'(wb_valid), 64'(exp_complete));
        check("mem_read_en", 64'(mem_read_en), 64'(occ && ld && !mis));
        check("mem_write_en", 64'(mem_write_en), 64'(occ && first && st && !mis));
        check("mem_wmask", 64'(mem_wmask), 64'((occ && st) ? oh : 4'b0));
        check("mem_read_size", 64'(mem_read_size), 64'((occ && ld) ? oh : 4'b0));
        check("zero_extends", 64'(zero_extends), 64'(occ && ld && cur.f3[2]));
        if (occ) begin
            check("mem_addr", mem_addr, cur.addr);
            check("mem_write_data", mem_write_data, cur.sdata);
        end
        check("wb_rd", 64'(wb_rd), 64'(exp_complete ? cur.rd : h_rd));
        check("wb_reg_write", 64'(wb_reg_write), 64'(exp_complete ? rw : h_rw));
        check("wb_is_load", 64'(wb_is_load), 64'(exp_complete ? ld : h_ld));
        check("wb_alu_result", wb_alu_result, exp_complete ? cur.addr : h_alu);
        check("wb_misaligned", 64'(wb_misaligned), 64'(exp_complete ? mis : h_mis));
        if (exp_complete) begin
            h_rd = cur.rd; h_rw = rw; h_ld = ld; h_alu = cur.addr; h_mis = mis;
        end
    endtask

    // One cycle: drive at negedge, check mid-cycle, advance the model at the posedge.
    task automatic step(input bit v, input op_t o, input bit stl);
        bit acc;
        ex_valid = v; ex_alu_result = o.addr; ex_store_data = o.sdata; ex_funct3 = o.f3;
        ex_is_load = o.ld; ex_is_store = o.st; ex_rd = o.rd; ex_reg_write = o.rw;
        stall_from_mem = stl;
        #2;
        check_cycle();
        acc = v && (!occ || exp_complete);
        @(posedge ACLK);
        if (acc) begin
            cur = o; occ = 1; first = 1;
        end else if (exp_complete) begin
            occ = 0;
        end else begin
            first = 0;
        end
        @(negedge ACLK);
    endtask

    op_t nop_op, q_op;
    int  not_ready;

    initial begin
        model_reset();
        nop_op = '0;
        ARESET = 1'b1;
        ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
        ex_is_load = 0; ex_is_store = 0; ex_rd = '0; ex_reg_write = 0; stall_from_mem = 0;
        #12;
        check("rst ex_ready", 64'(ex_ready), 64'd1);
        check("rst outputs", {mem_addr[31:0], mem_wmask, mem_read_size, 3'b0, mem_write_en,
                              mem_read_en, zero_extends, wb_valid, wb_reg_write, wb_is_load,
                              wb_misaligned, wb_rd, 1'b0}, 64'd0);
        check("rst wb_alu_result", wb_alu_result, 64'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        step(0, nop_op, 0);

        // Back-to-back sb then sd.
        step(1, mk(64'h8000_0003, 3'b000, 0, 1, 5'd1, 0, 64'h1122_3344_5566_7788), 0);
        step(1, mk(64'h8000_0010, 3'b011, 0, 1, 5'd2, 0, 64'hCAFE_F00D_0000_0001), 0);
        step(0, nop_op, 0);
        step(0, nop_op, 0);

        // lhu with a four-cycle stall and a queued ALU op waiting behind it.
        q_op = mk(64'h1234, 3'b000, 0, 0, 5'd7, 1, 64'h0);
        step(1, mk(64'h8000_0002, 3'b101, 1, 0, 5'd3, 1, 64'h0), 1);
        not_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #2 if (!ex_ready) not_ready++;
            #0 step(1, q_op, 1);
        end
        check("lhu stall ex_ready low cycles", 64'(not_ready), 64'd4);
        step(1, mk(64'h8000_0000, 3'b010, 1, 0, 5'd8, 1, 64'h0), 0);
        step(0, nop_op, 0);
        step(0, nop_op, 0);

        // Misaligned lw, ALU pass-through, aligned signed lw.
        step(1, mk(64'h8000_0006, 3'b010, 1, 0, 5'd4, 1, 64'h0), 0);
        step(1, mk(64'hDEAD_BEEF, 3'b000, 0, 0, 5'd5, 1, 64'h0), 0);
        step(1, mk(64'h8000_0004, 3'b010, 1, 0, 5'd6, 1, 64'h0), 0);
        step(0, nop_op, 0);

        // Reset while a load is stalled.
        step(1, mk(64'h8000_0008, 3'b011, 1, 0, 5'd9, 1, 64'h0), 1);
        for (int i = 0; i < 3; i++) step(0, nop_op, 1);
        #3 ARESET = 1'b1;
        #1;
        check("async rst mem_read_en", 64'(mem_read_en), 64'd0);
        check("async rst wb_valid", 64'(wb_valid), 64'd0);
        check("async rst ex_ready", 64'(ex_ready), 64'd1);
        model_reset();
        @(negedge ACLK);
        ARESET = 1'b0;
        step(0, nop_op, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            op_t o;
            int  kind;
            kind = $urandom_range(0, 9);
            o.addr  = {32'h8000_0000, $urandom} & 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 1) == 0) o.addr[2:0] = 3'b000;
            o.sdata = {$urandom, $urandom};
            o.f3    = 3'($urandom_range(0, 7));
            o.ld    = (kind < 4) || (kind == 9);
            o.st    = (kind >= 4 && kind < 7) || (kind == 9);
            o.rd    = 5'($urandom_range(0, 31));
            o.rw    = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, o, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
